// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: a round-robin arbiter picks one byte at a
// time and a small FSM frames it as start bit, LSB-first data and stop bits.
// Every line change is paced by baud_tick.
module uart_tx_scheduler #(
  parameter int DATA_BITS = 8,  // data bits per frame, 5..9
  parameter int STOP_BITS = 1   // stop bit periods, 1 or 2
) (
  input  logic                 clk,
  input  logic                 reset,       // asynchronous, active low
  input  logic                 baud_tick,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 frame_done
);

  localparam int CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 frame_done_q, frame_done_d;

  logic winner;
  logic xfer;

  // Round-robin pick; ready is only offered while idle and out of reset.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_q;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    req0_ready = (state_q == IDLE) && reset && req0_valid && !winner;
    req1_ready = (state_q == IDLE) && reset && req1_valid &&  winner;
    xfer       = req0_ready || req1_ready;
  end

  // Next-state logic: the frame advances only on baud ticks.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A tick in the accept cycle is deliberately ignored.
        if (xfer) begin
          shift_d      = winner ? req1_data : req0_data;
          grant_d      = winner;
          last_grant_d = winner;
          busy_d       = 1'b1;
          state_d      = WAIT_START;
        end
      end
      WAIT_START: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = '0;
            state_d    = STOP;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q != LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default 8N1 instance plus a 7-bit,
// two-stop-bit instance with baud_tick tied high.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic       r0_valid, r1_valid;
  logic [7:0] r0_data, r1_data;
  logic       r0_ready, r1_ready;
  logic       tx, busy, grant_id, frame_done;

  logic       v2;
  logic [6:0] d2;
  logic       r2_ready, r2b_ready, tx2, busy2, gid2, fd2;

  int n_checks = 0;
  int n_errors = 0;
  int c0 = 0;
  int c1 = 0;
  logic cnt_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_scheduler u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .baud_tick (baud_tick),
    .req0_valid(r0_valid),
    .req0_data (r0_data),
    .req0_ready(r0_ready),
    .req1_valid(r1_valid),
    .req1_data (r1_data),
    .req1_ready(r1_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_done(frame_done)
  );

  uart_tx_scheduler #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
    .clk       (clk),
    .reset     (rst_n),
    .baud_tick (1'b1),
    .req0_valid(v2),
    .req0_data (d2),
    .req0_ready(r2_ready),
    .req1_valid(1'b0),
    .req1_data (7'h00),
    .req1_ready(r2b_ready),
    .tx        (tx2),
    .busy      (busy2),
    .grant_id  (gid2),
    .frame_done(fd2)
  );

  // Count accepted handshakes per requester during the contention test.
  always @(posedge clk) begin
    if (cnt_en) begin
      c0 <= c0 + (r0_ready ? 1 : 0);
      c1 <= c1 + (r1_ready ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tick(input int gap);
    repeat (gap - 1) step();
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
  endtask

  // Checks the full 10-period frame for byte b, ending on the frame_done cycle.
  task automatic check_frame(input string tag, input logic [7:0] b, input int gap);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_tick(gap);
      check($sformatf("%s_bit%0d", tag, i), tx, bits[i]);
      check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
    end
    check($sformatf("%s_nodone", tag), frame_done, 1'b0);
    send_tick(gap);
    check($sformatf("%s_done", tag), frame_done, 1'b1);
    check($sformatf("%s_idle", tag), busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; baud_tick = 1'b0;
    r0_valid = 1'b1; r0_data = 8'hA5;
    r1_valid = 1'b1; r1_data = 8'h00;
    v2 = 1'b0; d2 = 7'h55;
    repeat (2) step();

    // Reset values, even with requests pending.
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_gid", grant_id, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_r0", r0_ready, 1'b0);
    check("rst_r1", r1_ready, 1'b0);
    r1_valid = 1'b0; r0_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single frame 0xA5 at 104 clocks per bit.
    r0_valid = 1'b1; r0_data = 8'hA5;
    #1;
    check("a5_r0", r0_ready, 1'b1);
    check("a5_r1", r1_ready, 1'b0);
    step();
    r0_valid = 1'b0;
    check("a5_busy", busy, 1'b1);
    check("a5_gid", grant_id, 1'b0);
    check("a5_hold", tx, 1'b1);
    check_frame("a5", 8'hA5, 104);
    step();
    check("a5_pulse", frame_done, 1'b0);

    // Tie after reset: requester 0 first, loser waits for IDLE.
    do_reset();
    r0_valid = 1'b1; r0_data = 8'h11;
    r1_valid = 1'b1; r1_data = 8'h22;
    #1;
    check("tie_r0", r0_ready, 1'b1);
    check("tie_r1", r1_ready, 1'b0);
    step();
    r0_valid = 1'b0;
    check("tie_gid0", grant_id, 1'b0);
    step();
    check("tie_wait_r1", r1_ready, 1'b0);
    check_frame("tie11", 8'h11, 5);
    check("tie_r1_idle", r1_ready, 1'b1);
    step();
    r1_valid = 1'b0;
    check("tie_gid1", grant_id, 1'b1);
    check_frame("tie22", 8'h22, 5);

    // Continuous contention over four frames.
    do_reset();
    r0_valid = 1'b1; r0_data = 8'h55;
    r1_valid = 1'b1; r1_data = 8'h0F;
    cnt_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), (k % 2 == 0) ? r0_ready : r1_ready, 1'b1);
      step();
      check($sformatf("rr_gid%0d", k), grant_id, k[0]);
      check_frame($sformatf("rr%0d", k), (k % 2 == 0) ? 8'h55 : 8'h0F, 3);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    cnt_en = 1'b0;
    check("rr_cnt0", c0, 2);
    check("rr_cnt1", c1, 2);

    // Tick coincident with the accept cycle is ignored.
    r0_valid = 1'b1; r0_data = 8'h96;
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
    r0_valid = 1'b0;
    check("coin_busy", busy, 1'b1);
    check("coin_tx", tx, 1'b1);
    step();
    check("coin_still", tx, 1'b1);
    check_frame("coin", 8'h96, 4);

    // Reset during data bit 4 aborts; then a clean 0x3C frame.
    step();
    r0_valid = 1'b1; r0_data = 8'h0F;
    step();
    r0_valid = 1'b0;
    repeat (6) send_tick(4);
    check("abort_bit4", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", frame_done, 1'b0);
    repeat (3) step();
    check("abort_nodone", frame_done, 1'b0);
    rst_n = 1'b1;
    step();
    r0_valid = 1'b1; r0_data = 8'h3C;
    step();
    r0_valid = 1'b0;
    check("post_gid", grant_id, 1'b0);
    check_frame("post3c", 8'h3C, 4);

    // 7 data bits, 2 stop bits, baud_tick tied high.
    v2 = 1'b1; d2 = 7'h55;
    #1;
    check("s2_ready", r2_ready, 1'b1);
    step();
    v2 = 1'b0;
    check("s2_hold", tx2, 1'b1);
    check("s2_busy", busy2, 1'b1);
    begin
      logic [9:0] exp2;
      exp2 = {2'b11, 7'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
        step();
        check($sformatf("s2_bit%0d", i), tx2, exp2[i]);
        check($sformatf("s2_nodone%0d", i), fd2, 1'b0);
      end
    end
    step();
    check("s2_done", fd2, 1'b1);
    check("s2_idle", busy2, 1'b0);
    check("s2_line", tx2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
